img_timing_gen: RTL and testbench
=================================

IMG_TIMING_GEN -- requirements
Module: img_timing_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width; patterns use bits [7:0], zero-extended above bit 7, truncated below.
REQ-002 SHALL have parameters H_SYNC/H_BACK/H_DISP/H_FRONT/H_TOTAL, defaults 11'd40/11'd220/11'd1280/11'd110/11'd1650, horizontal timing in clocks.
REQ-003 SHALL have parameters V_SYNC/V_BACK/V_DISP/V_FRONT/V_TOTAL, defaults 11'd5/11'd20/11'd720/11'd5/11'd750, vertical timing in lines.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  run request; level-sensitive.
REQ-007 pattern_sel  input  2  pattern: 0 h-ramp, 1 v-ramp, 2 checkerboard, 3 moving diagonal.
REQ-008 post_img_vsync  output  1  active-high vertical sync, registered.
REQ-009 post_img_hsync  output  1  active-high horizontal sync, registered.
REQ-010 post_img_valid  output  1  active-pixel qualifier, registered.
REQ-011 post_img_data  output  DATA_WIDTH  pixel value, registered.
REQ-012 frame_done  output  1  one-cycle pulse coincident with last valid pixel of a frame.

Function
REQ-013 SHALL hold 11-bit h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1); h_cnt wraps to 0 and v_cnt increments at h_cnt=H_TOTAL-1; v_cnt wraps to 0 at V_TOTAL-1 on that same cycle.
REQ-014 SHALL implement FSM IDLE, RUN, STOP_PEND; counters held at 0 in IDLE.
REQ-015 IDLE->RUN when en=1 at a clock edge; counters start at (0,0) after that edge.
REQ-016 RUN->STOP_PEND when en=0; counters keep running.
REQ-017 STOP_PEND->RUN when en=1 (no gap, no counter disturbance); STOP_PEND->IDLE at the edge where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
REQ-018 Outputs at cycle n SHALL reflect counters/state at cycle n-1 (1-cycle latency); all outputs 0 when the source state is IDLE.
REQ-019 hsync = (h_cnt < H_SYNC); vsync = (v_cnt < V_SYNC), for whole lines.
REQ-020 valid = h_act AND v_act; h_act = H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP; v_act analogous.
REQ-021 x = h_cnt-(H_SYNC+H_BACK), y = v_cnt-(V_SYNC+V_BACK); pattern 0: x[7:0]; 1: y[7:0]; 2: (x[3]^y[3]) ? 8'hFF : 8'h00; 3: (x+y+frame_cnt)[7:0], modulo 256.
REQ-022 post_img_data SHALL be 0 whenever post_img_valid=0.
REQ-023 pattern_sel SHALL be latched only at counter position (0,0) in RUN/STOP_PEND and on IDLE->RUN; mid-frame changes ignored until next frame.
REQ-024 8-bit frame_cnt SHALL increment at each frame wrap (v_cnt, h_cnt at max), wrapping 255->0; cleared on entering IDLE.
REQ-025 frame_done SHALL be 1 only on the output cycle of pixel (x=H_DISP-1, y=V_DISP-1).

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, h_cnt=v_cnt=0, frame_cnt=0, pattern latch=0, and all outputs 0, including mid-frame.
REQ-027 After rst_n release, the block SHALL remain in IDLE until en=1 is sampled.

Verification
Small parameters: H 2/2/8/2/14, V 1/1/4/1/7; frame = 98 cycles.
REQ-028 en=1 sampled at edge E0, pattern 0.
  -> hsync=vsync=1 after E1; first valid after E33 with data=0.
  -> data 0..7 across the line; exactly 32 valid per frame; frame_done once per frame.
REQ-029 pattern 2 with H_DISP=16, V_DISP=16 (H_TOTAL=22, V_TOTAL=19).
  -> row 0: x=0..7 data 00, x=8..15 data FF; row 8 inverted.
REQ-030 en dropped mid-frame 1.
  -> frame completes fully (32 valid, frame_done).
  -> outputs 0 from the cycle after the wrap; counters stay 0.
  -> en reasserted during STOP_PEND: frames continue without gap.
REQ-031 pattern_sel 0->1 changed at line 3 of a frame.
  -> rest of that frame stays pattern 0; next frame row y outputs data=y.
REQ-032 pattern 3 over 257 frames.
  -> pixel (0,0) data equals frame index mod 256, wrapping 255->0.
REQ-033 rst_n pulsed low mid-active line.
  -> all outputs 0 asynchronously; after release with en=1, first valid 33 cycles after the start edge.

Source files
------------

// File: rtl/img_timing_gen.sv
// Video timing generator with built-in test patterns: free-running h/v counters
// under an IDLE/RUN/STOP_PEND controller, one registered output stage.
module img_timing_gen #(
    parameter int          DATA_WIDTH = 8,
    parameter logic [10:0] H_SYNC     = 11'd40,
    parameter logic [10:0] H_BACK     = 11'd220,
    parameter logic [10:0] H_DISP     = 11'd1280,
    parameter logic [10:0] H_FRONT    = 11'd110,
    parameter logic [10:0] H_TOTAL    = 11'd1650,
    parameter logic [10:0] V_SYNC     = 11'd5,
    parameter logic [10:0] V_BACK     = 11'd20,
    parameter logic [10:0] V_DISP     = 11'd720,
    parameter logic [10:0] V_FRONT    = 11'd5,
    parameter logic [10:0] V_TOTAL    = 11'd750
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            pattern_sel,
    output logic                  post_img_vsync,
    output logic                  post_img_hsync,
    output logic                  post_img_valid,
    output logic [DATA_WIDTH-1:0] post_img_data,
    output logic                  frame_done
);

    localparam logic [10:0] H_LAST  = H_TOTAL - 11'd1;
    localparam logic [10:0] V_LAST  = V_TOTAL - 11'd1;
    localparam logic [10:0] H_ACT_S = H_SYNC + H_BACK;
    localparam logic [10:0] H_ACT_E = H_SYNC + H_BACK + H_DISP;
    localparam logic [10:0] V_ACT_S = V_SYNC + V_BACK;
    localparam logic [10:0] V_ACT_E = V_SYNC + V_BACK + V_DISP;
    localparam logic [10:0] X_LAST  = H_DISP - 11'd1;
    localparam logic [10:0] Y_LAST  = V_DISP - 11'd1;

    // Inconsistent timing sets are rejected at elaboration.
    if ((H_SYNC + H_BACK + H_DISP + H_FRONT != H_TOTAL) ||
        (V_SYNC + V_BACK + V_DISP + V_FRONT != V_TOTAL)) begin : g_bad_timing
        $error("img_timing_gen: porch/sync/display widths do not sum to totals");
    end

    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

    state_t      state, state_nxt;
    logic [10:0] h_cnt, v_cnt;
    logic [7:0]  frame_cnt;
    logic [1:0]  pat_lat;
    logic        h_end, frame_end;

    function automatic logic [DATA_WIDTH-1:0] fit_px(input logic [7:0] v);
        logic [DATA_WIDTH+7:0] ext;
        ext = {{DATA_WIDTH{1'b0}}, v};
        return ext[DATA_WIDTH-1:0];
    endfunction

    assign h_end     = (h_cnt == H_LAST);
    assign frame_end = h_end && (v_cnt == V_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (en) state_nxt = RUN;
            RUN:       if (!en) state_nxt = STOP_PEND;
            STOP_PEND: begin
                if (en)             state_nxt = RUN;
                else if (frame_end) state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
            pat_lat   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                h_cnt     <= '0;
                v_cnt     <= '0;
                frame_cnt <= '0;
                if (en) pat_lat <= pattern_sel;
            end else begin
                // Pattern changes only take effect from the top of a frame.
                if (h_cnt == '0 && v_cnt == '0) pat_lat <= pattern_sel;
                h_cnt <= h_end ? '0 : h_cnt + 11'd1;
                if (h_end) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
                if (state_nxt == IDLE) frame_cnt <= '0;
                else if (frame_end)    frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Stage p0: combinational decode of the current counters
    logic                  run_p0, hs_p0, vs_p0, vld_p0, fd_p0;
    logic [10:0]           x_p0, y_p0;
    logic [7:0]            px_p0;
    logic [DATA_WIDTH-1:0] data_p0;

    always_comb begin
        run_p0 = (state != IDLE);
        x_p0   = h_cnt - H_ACT_S;
        y_p0   = v_cnt - V_ACT_S;
        hs_p0  = run_p0 && (h_cnt < H_SYNC);
        vs_p0  = run_p0 && (v_cnt < V_SYNC);
        vld_p0 = run_p0 && (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E) &&
                 (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
        case (pat_lat)
            2'd0:    px_p0 = x_p0[7:0];
            2'd1:    px_p0 = y_p0[7:0];
            2'd2:    px_p0 = (x_p0[3] ^ y_p0[3]) ? 8'hFF : 8'h00;
            default: px_p0 = x_p0[7:0] + y_p0[7:0] + frame_cnt;
        endcase
        data_p0 = vld_p0 ? fit_px(px_p0) : '0;
        fd_p0   = vld_p0 && (x_p0 == X_LAST) && (y_p0 == Y_LAST);
    end

    // Stage p1: registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_vsync <= 1'b0;
            post_img_hsync <= 1'b0;
            post_img_valid <= 1'b0;
            post_img_data  <= '0;
            frame_done     <= 1'b0;
        end else begin
            post_img_vsync <= vs_p0;
            post_img_hsync <= hs_p0;
            post_img_valid <= vld_p0;
            post_img_data  <= data_p0;
            frame_done     <= fd_p0;
        end
    end

endmodule

// File: tb/tb_img_timing_gen.sv
// Scoreboard bench for img_timing_gen using small timing sets.
module tb_img_timing_gen;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [1:0] pat_a, pat_b;
    logic       vs_a, hs_a, vld_a, fd_a;
    logic [7:0] data_a;
    logic       vs_b, hs_b, vld_b, fd_b;
    logic [7:0] data_b;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cnt_va = 0;
    int   cnt_fd = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    img_timing_gen #(
        .DATA_WIDTH(8),
        .H_SYNC(11'd2), .H_BACK(11'd2), .H_DISP(11'd8), .H_FRONT(11'd2), .H_TOTAL(11'd14),
        .V_SYNC(11'd1), .V_BACK(11'd1), .V_DISP(11'd4), .V_FRONT(11'd1), .V_TOTAL(11'd7)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .pattern_sel(pat_a),
        .post_img_vsync(vs_a), .post_img_hsync(hs_a), .post_img_valid(vld_a),
        .post_img_data(data_a), .frame_done(fd_a)
    );

    img_timing_gen #(
        .DATA_WIDTH(8),
        .H_SYNC(11'd2), .H_BACK(11'd2), .H_DISP(11'd16), .H_FRONT(11'd2), .H_TOTAL(11'd22),
        .V_SYNC(11'd1), .V_BACK(11'd1), .V_DISP(11'd16), .V_FRONT(11'd1), .V_TOTAL(11'd19)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .pattern_sel(pat_b),
        .post_img_vsync(vs_b), .post_img_hsync(hs_b), .post_img_valid(vld_b),
        .post_img_data(data_b), .frame_done(fd_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_a(output int e0);
        @(negedge clk);
        en_a = 1'b1;
        e0 = cyc + 1;
    endtask

    // Small set: pixel (x,y) of frame k leaves the DUT after edge e0+98k+(2+y)*14+(4+x)+1.
    task automatic push_frame_a(input int e0, input int k, input int pat, input int rows, input int cols);
        exp_t e;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < cols; x++) begin
                e.cyc = e0 + 98 * k + (2 + y) * 14 + (4 + x) + 1;
                case (pat)
                    0:       e.data = 8'(x);
                    1:       e.data = 8'(y);
                    default: e.data = 8'((x + y + k) % 256);
                endcase
                e.fd = (x == 7) && (y == 3);
                qa.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (vld_a) begin
                cnt_va++;
                if (fd_a) cnt_fd++;
                if (qa.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid_a @cycle %0d: got valid with data %0h, expected none", cyc, data_a);
                end else begin
                    ea = qa.pop_front();
                    check("cycle_a", cyc, ea.cyc);
                    check("data_a", {24'd0, data_a}, {24'd0, ea.data});
                    check("fdone_a", {31'd0, fd_a}, {31'd0, ea.fd});
                end
            end else begin
                check("blank_a", {23'd0, data_a, fd_a}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && vld_b) begin
            if (qb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid_b @cycle %0d: got valid with data %0h, expected none", cyc, data_b);
            end else begin
                eb = qb.pop_front();
                check("cycle_b", cyc, eb.cyc);
                check("data_b", {24'd0, data_b}, {24'd0, eb.data});
                check("fdone_b", {31'd0, fd_b}, {31'd0, eb.fd});
            end
        end
    end

    initial begin
        int   e0;
        exp_t e;
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        pat_a = 2'd0;
        pat_b = 2'd2;
        repeat (3) @(negedge clk);
        check("reset_a", {28'd0, vs_a, hs_a, vld_a, fd_a}, 32'd0);
        check("reset_data_a", {24'd0, data_a}, 32'd0);
        check("reset_b", {28'd0, vs_b, hs_b, vld_b, fd_b}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset", {29'd0, vs_a, hs_a, vld_a}, 32'd0);

        // Pattern 0, two frames, en dropped mid frame 1.
        start_a(e0);
        push_frame_a(e0, 0, 0, 4, 8);
        push_frame_a(e0, 1, 0, 4, 8);
        wait_cyc(e0 + 1);
        check("sync_first", {30'd0, hs_a, vs_a}, 32'd3);
        wait_cyc(e0 + 3);
        check("hsync_end", {30'd0, hs_a, vs_a}, 32'd1);
        wait_cyc(e0 + 15);
        check("vsync_end", {30'd0, hs_a, vs_a}, 32'd2);
        wait_cyc(e0 + 148);
        en_a = 1'b0;
        for (int c = e0 + 197; c < e0 + 215; c++) begin
            wait_cyc(c);
            check("stopped_a", {29'd0, vs_a, hs_a, vld_a}, 32'd0);
        end
        check("valid_count", cnt_va, 32'd64);
        check("fdone_count", cnt_fd, 32'd2);

        // Pattern switch at line 3, plus en drop/reassert inside frame 0.
        start_a(e0);
        push_frame_a(e0, 0, 0, 4, 8);
        push_frame_a(e0, 1, 1, 4, 8);
        wait_cyc(e0 + 47);
        pat_a = 2'd1;
        wait_cyc(e0 + 60);
        en_a = 1'b0;
        wait_cyc(e0 + 80);
        en_a = 1'b1;
        wait_cyc(e0 + 138);
        en_a = 1'b0;
        wait_cyc(e0 + 200);
        check("stopped_b_run", {29'd0, vs_a, hs_a, vld_a}, 32'd0);

        // Moving diagonal across 257 frames: frame_cnt wraps 255 -> 0.
        pat_a = 2'd3;
        start_a(e0);
        for (int k = 0; k < 257; k++) push_frame_a(e0, k, 3, 4, 8);
        wait_cyc(e0 + 256 * 98 + 10);
        en_a = 1'b0;
        wait_cyc(e0 + 257 * 98 + 4);
        check("diag_queue_empty", qa.size(), 32'd0);

        // Asynchronous reset in the middle of the first active line.
        pat_a = 2'd0;
        start_a(e0);
        push_frame_a(e0, 0, 0, 1, 4);
        wait_cyc(e0 + 36);
        #2;
        rst_n = 1'b0;
        en_a  = 1'b0;
        #1;
        check("async_rst_ctl", {28'd0, vs_a, hs_a, vld_a, fd_a}, 32'd0);
        check("async_rst_data", {24'd0, data_a}, 32'd0);
        check("rst_queue_empty", qa.size(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_rst", {29'd0, vs_a, hs_a, vld_a}, 32'd0);
        start_a(e0);
        push_frame_a(e0, 0, 0, 4, 8);
        wait_cyc(e0 + 10);
        en_a = 1'b0;
        wait_cyc(e0 + 105);
        check("restart_queue_empty", qa.size(), 32'd0);

        // Checkerboard on the 16x16 set.
        @(negedge clk);
        en_b = 1'b1;
        e0 = cyc + 1;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                e.cyc  = e0 + (2 + y) * 22 + (4 + x) + 1;
                e.data = (((x / 8) + (y / 8)) % 2 == 1) ? 8'hFF : 8'h00;
                e.fd   = (x == 15) && (y == 15);
                qb.push_back(e);
            end
        end
        wait_cyc(e0 + 10);
        en_b = 1'b0;
        wait_cyc(e0 + 418 + 5);
        check("checker_queue_empty", qb.size(), 32'd0);
        check("final_queue_a_empty", qa.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
